// File: rtl/sub_sequencer_pkg.sv
// ============================================================================
// Module : sub_sequencer_pkg
// Brief  : State encodings and opcode constants for the nibble-serial add/sub.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sub_sequencer_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_NEG_LO = 3'd1,
      S_NEG_HI = 3'd2,
      S_ADD_LO = 3'd3,
      S_ADD_HI = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

`default_nettype wire

// File: rtl/sub_sequencer_if.sv
// ============================================================================
// Module : sub_sequencer_if
// Brief  : Request/response bundle between the operand registers and the unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface sub_sequencer_if;
   logic       start;
   logic       op;
   logic [7:0] a;
   logic [7:0] b;
   logic       ready_in;
   logic [7:0] result;
   logic       carry;
   logic       overflow;
   logic       zero;
   logic       negative;
   logic       done;

   modport master (
      output start, op, a, b,
      input  ready_in, result, carry, overflow, zero, negative, done
   );

   modport slave (
      input  start, op, a, b,
      output ready_in, result, carry, overflow, zero, negative, done
   );
endinterface

`default_nettype wire

// File: rtl/sub_sequencer_nibble_adder.sv
// ============================================================================
// Module : nibble_adder
// Brief  : Combinational 4-bit adder with carry in/out.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module nibble_adder (
   input  wire logic [3:0] a,
   input  wire logic [3:0] b,
   input  wire logic       c_in,
   output logic      [3:0] sum,
   output logic            c_out
);

   logic [4:0] w_full;

   assign w_full = {1'b0, a} + {1'b0, b} + {4'b0000, c_in};
   assign sum    = w_full[3:0];
   assign c_out  = w_full[4];

endmodule

`default_nettype wire

// File: rtl/sub_sequencer.sv
// ============================================================================
// Module : sub_sequencer
// Brief  : 8-bit add/subtract using one shared nibble adder over several cycles.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sub_sequencer
   import sub_sequencer_pkg::*;
(
   input  wire logic        clk,
   input  wire logic        rst_n,
   sub_sequencer_if.slave   bus
);

   state_t     r_state;
   state_t     w_next;
   logic       w_ready;
   logic       w_done;

   logic [7:0] r_a;
   logic [7:0] r_b;
   logic       r_op;
   logic [7:0] r_nb;
   logic       r_c;
   logic       r_neg_carry;
   logic [3:0] r_lo;

   logic [7:0] r_result;
   logic       r_carry;
   logic       r_overflow;
   logic       r_zero;
   logic       r_negative;

   logic [3:0] w_add_a;
   logic [3:0] w_add_b;
   logic       w_add_cin;
   logic [3:0] w_sum;
   logic       w_cout;
   logic [7:0] w_opb;
   logic [7:0] w_res;
   logic       w_ovf;

   nibble_adder u_nibble_adder (
      .a     (w_add_a),
      .b     (w_add_b),
      .c_in  (w_add_cin),
      .sum   (w_sum),
      .c_out (w_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_ready = 1'b0;
      w_done  = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            w_ready = 1'b1;
            w_done  = (r_state == S_DONE);
            if (bus.start) w_next = (bus.op == OP_SUB) ? S_NEG_LO : S_ADD_LO;
            else           w_next = S_IDLE;
         end
         S_NEG_LO: w_next = S_NEG_HI;
         S_NEG_HI: w_next = S_ADD_LO;
         S_ADD_LO: w_next = S_ADD_HI;
         S_ADD_HI: w_next = S_DONE;
         default:  w_next = S_IDLE;
      endcase
   end

   assign w_opb = (r_op == OP_SUB) ? r_nb : r_b;

   // Single adder shared across phases: negation (~b + 1) then the real add.
   always_comb begin
      w_add_a   = 4'h0;
      w_add_b   = 4'h0;
      w_add_cin = 1'b0;
      case (r_state)
         S_NEG_LO: begin w_add_a = ~r_b[3:0]; w_add_cin = 1'b1;          end
         S_NEG_HI: begin w_add_a = ~r_b[7:4]; w_add_cin = r_c;           end
         S_ADD_LO: begin w_add_a = r_a[3:0];  w_add_b = w_opb[3:0];      end
         S_ADD_HI: begin w_add_a = r_a[7:4];  w_add_b = w_opb[7:4];
                         w_add_cin = r_c;                                end
         default:  begin w_add_a = 4'h0;                                 end
      endcase
   end

   assign w_res = {w_sum, r_lo};
   // Overflow judged against the original b, so b=0x80 needs no special case.
   assign w_ovf = (r_op == OP_SUB) ? ((r_a[7] != r_b[7]) && (w_res[7] != r_a[7]))
                                   : ((r_a[7] == r_b[7]) && (w_res[7] != r_a[7]));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a         <= 8'h00;
         r_b         <= 8'h00;
         r_op        <= OP_ADD;
         r_nb        <= 8'h00;
         r_c         <= 1'b0;
         r_neg_carry <= 1'b0;
         r_lo        <= 4'h0;
         r_result    <= 8'h00;
         r_carry     <= 1'b0;
         r_overflow  <= 1'b0;
         r_zero      <= 1'b0;
         r_negative  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  r_a         <= bus.a;
                  r_b         <= bus.b;
                  r_op        <= bus.op;
                  r_c         <= 1'b0;
                  r_neg_carry <= 1'b0;
               end
            end
            S_NEG_LO: begin
               r_nb[3:0] <= w_sum;
               r_c       <= w_cout;
            end
            S_NEG_HI: begin
               r_nb[7:4]   <= w_sum;
               r_neg_carry <= w_cout;
            end
            S_ADD_LO: begin
               r_lo <= w_sum;
               r_c  <= w_cout;
            end
            S_ADD_HI: begin
               r_result   <= w_res;
               r_carry    <= w_cout | ((r_op == OP_SUB) & r_neg_carry);
               r_overflow <= w_ovf;
               r_zero     <= (w_res == 8'h00);
               r_negative <= w_res[7];
            end
            default: begin
               r_c <= r_c;
            end
         endcase
      end
   end

   assign bus.ready_in = w_ready;
   assign bus.done     = w_done;
   assign bus.result   = r_result;
   assign bus.carry    = r_carry;
   assign bus.overflow = r_overflow;
   assign bus.zero     = r_zero;
   assign bus.negative = r_negative;

endmodule

`default_nettype wire
